// File: rtl/fp_pkg.sv
// Shared types for the floating-point multiplier: FSM states, rounding modes,
// flag bit positions and operand classification.
package fp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_MULT,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_e;

   typedef enum logic {
      RND_RNE = 1'b0,
      RND_RTZ = 1'b1
   } rnd_mode_e;

   localparam int FLAG_INX = 0;
   localparam int FLAG_UDF = 1;
   localparam int FLAG_OVF = 2;
   localparam int FLAG_INV = 3;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   // Width-independent: callers reduce their exponent/fraction fields first.
   function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                             input logic frac_zero, input logic frac_msb);
      if (exp_zero) return frac_zero ? CLS_ZERO : CLS_SUB;
      if (!exp_ones) return CLS_NORM;
      if (frac_zero) return CLS_INF;
      return frac_msb ? CLS_QNAN : CLS_SNAN;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH = 22,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] count
);

   // Scanning upward lets the highest set bit have the final say.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// Multi-cycle IEEE-style floating-point multiplier, one FSM state per stage,
// single-issue with a valid/ready handshake on both sides.
module fp_mult_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   rnd_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int W      = 1 + EXP_W + MAN_W;
   localparam int SW     = MAN_W + 1;
   localparam int PW     = 2 * SW;
   localparam int EW     = EXP_W + 2;
   localparam int LZW    = $clog2(PW + 1);
   localparam int XW     = EW + LZW;
   localparam int SH_MAX = MAN_W + 3;
   localparam int SHW    = $clog2(SH_MAX + 1);
   localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - 1'b1;
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   state_e            state_reg, state_next;
   logic [W-1:0]      a_reg, b_reg;
   rnd_mode_e         rnd_reg;
   logic              sign_reg, spec_reg, spec_inv_reg, tiny_reg;
   logic [W-1:0]      spec_res_reg;
   logic [SW-1:0]     sig_a_reg, sig_b_reg;
   logic [EXP_W-1:0]  exp_a_reg, exp_b_reg;
   logic [PW-1:0]     prod_reg, norm_reg;
   logic [EW-1:0]     exp_m_reg;
   logic [EXP_W:0]    exp_n_reg;
   logic [W-1:0]      result_reg;
   logic [3:0]        flags_reg;
   logic              out_valid_reg;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (in_valid) state_next = ST_UNPACK;
         ST_UNPACK: state_next = ST_MULT;
         ST_MULT:   state_next = ST_NORM;
         ST_NORM:   state_next = ST_ROUND;
         ST_ROUND:  state_next = ST_DONE;
         ST_DONE:   if (out_valid_reg && out_ready) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_reg == ST_IDLE);
   end

   // ---------------- UNPACK ----------------
   logic [EXP_W-1:0] ea_f, eb_f;
   logic [MAN_W-1:0] fa, fb;
   fp_class_e        cls_a, cls_b;
   logic             sign_u, spec_next, spec_inv_next;
   logic [W-1:0]     spec_res_next;

   assign ea_f   = a_reg[W-2:MAN_W];
   assign eb_f   = b_reg[W-2:MAN_W];
   assign fa     = a_reg[MAN_W-1:0];
   assign fb     = b_reg[MAN_W-1:0];
   assign sign_u = a_reg[W-1] ^ b_reg[W-1];
   assign cls_a  = fp_classify(ea_f == '0, &ea_f, fa == '0, fa[MAN_W-1]);
   assign cls_b  = fp_classify(eb_f == '0, &eb_f, fb == '0, fb[MAN_W-1]);

   always_comb begin
      spec_next     = 1'b1;
      spec_inv_next = 1'b0;
      spec_res_next = '0;
      if (cls_a inside {CLS_QNAN, CLS_SNAN} || cls_b inside {CLS_QNAN, CLS_SNAN}) begin
         spec_res_next = QNAN;
         spec_inv_next = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
      end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                   (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
         spec_res_next = QNAN;
         spec_inv_next = 1'b1;
      end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
         spec_res_next = {sign_u, EXP_ONES, {MAN_W{1'b0}}};
      end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
         spec_res_next = {sign_u, {(W-1){1'b0}}};
      end else begin
         spec_next = 1'b0;
      end
   end

   // ---------------- NORM ----------------
   // Product has its unit bit at 2*MAN_W; after the shift the hidden bit sits at PW-1.
   logic [LZW-1:0]   lz;
   logic [PW-1:0]    shl, norm_next;
   logic [XW-1:0]    exp_x, sh_x;
   logic [SHW-1:0]   sh;
   logic             tiny_next, sticky_x;
   logic [EXP_W:0]   exp_n_next;

   fp_lzc #(.WIDTH(PW), .CNT_W(LZW)) u_lzc (
      .din   (prod_reg),
      .count (lz)
   );

   always_comb begin
      shl       = prod_reg << lz;
      exp_x     = {{(XW-EW){exp_m_reg[EW-1]}}, exp_m_reg} + XW'(1) - XW'(lz);
      tiny_next = exp_x[XW-1] || (exp_x == '0);
      sh_x      = XW'(1) - exp_x;
      sh        = '0;
      if (tiny_next) sh = (sh_x > XW'(SH_MAX)) ? SHW'(SH_MAX) : SHW'(sh_x);
      sticky_x   = |(shl & ~({PW{1'b1}} << sh));
      norm_next  = (shl >> sh) | {{(PW-1){1'b0}}, sticky_x};
      exp_n_next = tiny_next ? '0 : exp_x[EXP_W:0];
   end

   // ---------------- ROUND ----------------
   logic [SW-1:0]    mant0;
   logic [SW:0]      mant1;
   logic             g_bit, r_bit, s_bit, inc, inexact;
   logic [EXP_W:0]   exp_r;
   logic [MAN_W-1:0] frac_r;
   logic [W-1:0]     res_next;
   logic [3:0]       flg_next;

   always_comb begin
      mant0   = norm_reg[PW-1:MAN_W+1];
      g_bit   = norm_reg[MAN_W];
      r_bit   = norm_reg[MAN_W-1];
      s_bit   = |norm_reg[MAN_W-2:0];
      inexact = g_bit | r_bit | s_bit;
      inc     = (rnd_reg == RND_RNE) && g_bit && (r_bit || s_bit || mant0[0]);
      mant1   = {1'b0, mant0} + (SW+1)'(inc);
      // A subnormal whose rounding reaches the hidden bit becomes the minimum normal.
      if (mant1[SW]) begin
         exp_r  = exp_n_reg + (EXP_W+1)'(1);
         frac_r = '0;
      end else if (exp_n_reg == '0) begin
         exp_r  = {{EXP_W{1'b0}}, mant1[MAN_W]};
         frac_r = mant1[MAN_W-1:0];
      end else begin
         exp_r  = exp_n_reg;
         frac_r = mant1[MAN_W-1:0];
      end
      res_next           = {sign_reg, exp_r[EXP_W-1:0], frac_r};
      flg_next           = '0;
      flg_next[FLAG_INX] = inexact;
      flg_next[FLAG_UDF] = tiny_reg && inexact;
      if (exp_r >= {1'b0, EXP_ONES}) begin
         flg_next[FLAG_OVF] = 1'b1;
         flg_next[FLAG_INX] = 1'b1;
         flg_next[FLAG_UDF] = 1'b0;
         res_next = (rnd_reg == RND_RTZ) ? {sign_reg, EXP_MAXF, {MAN_W{1'b1}}}
                                         : {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
      end
      if (spec_reg) begin
         res_next           = spec_res_reg;
         flg_next           = '0;
         flg_next[FLAG_INV] = spec_inv_reg;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         a_reg   <= a;
         b_reg   <= b;
         rnd_reg <= rnd_mode_e'(rnd_mode);
      end
      if (state_reg == ST_UNPACK) begin
         sign_reg     <= sign_u;
         sig_a_reg    <= {ea_f != '0, fa};
         sig_b_reg    <= {eb_f != '0, fb};
         exp_a_reg    <= (ea_f == '0) ? EXP_W'(1) : ea_f;
         exp_b_reg    <= (eb_f == '0) ? EXP_W'(1) : eb_f;
         spec_reg     <= spec_next;
         spec_res_reg <= spec_res_next;
         spec_inv_reg <= spec_inv_next;
      end
      if (state_reg == ST_MULT) begin
         prod_reg  <= PW'(sig_a_reg) * PW'(sig_b_reg);
         exp_m_reg <= EW'(exp_a_reg) + EW'(exp_b_reg) - EW'(BIAS);
      end
      if (state_reg == ST_NORM) begin
         norm_reg  <= norm_next;
         exp_n_reg <= exp_n_next;
         tiny_reg  <= tiny_next;
      end
   end

   // Result lands on entry to DONE; out_valid follows one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_reg    <= '0;
         flags_reg     <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (state_reg == ST_ROUND) begin
            result_reg <= res_next;
            flags_reg  <= flg_next;
         end
         if (state_reg == ST_DONE) out_valid_reg <= !(out_valid_reg && out_ready);
         else                      out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign flags     = flags_reg;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed and random checks of fp_mult_pipe (binary16) against an
// integer ulp-quantisation model of IEEE multiplication.
module tb_fp_mult_pipe;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, rnd_mode, out_valid, out_ready;
   logic [W-1:0] a, b, result;
   logic [3:0]   flags;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_xfer = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (out_valid && out_ready) n_xfer <= n_xfer + 1;

   fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .rnd_mode  (rnd_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Product quantised to the binary16 ulp grid (min ulp 2^-24) with plain integers.
   function automatic void ref_mul(input logic [15:0] x, input logic [15:0] y, input logic rz,
                                   output logic [15:0] res, output logic [3:0] flg);
      logic       sg;
      logic [4:0] ex, ey;
      logic [9:0] fx, fy;
      bit         x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero, inexact, tiny;
      longint     mx, my, p, n, rem, half;
      int         e2, msb, lg, q, s, field;
      sg = x[15] ^ y[15];
      ex = x[14:10]; ey = y[14:10]; fx = x[9:0]; fy = y[9:0];
      x_nan  = (ex == 5'h1F) && (fx != 0);  y_nan  = (ey == 5'h1F) && (fy != 0);
      x_snan = x_nan && !fx[9];             y_snan = y_nan && !fy[9];
      x_inf  = (ex == 5'h1F) && (fx == 0);  y_inf  = (ey == 5'h1F) && (fy == 0);
      x_zero = (ex == 0) && (fx == 0);      y_zero = (ey == 0) && (fy == 0);
      res = '0;
      flg = '0;
      if (x_nan || y_nan) begin res = 16'h7E00; flg[3] = x_snan || y_snan; return; end
      if ((x_inf && y_zero) || (x_zero && y_inf)) begin res = 16'h7E00; flg[3] = 1'b1; return; end
      if (x_inf || y_inf) begin res = {sg, 5'h1F, 10'h000}; return; end
      if (x_zero || y_zero) begin res = {sg, 15'h0000}; return; end
      mx = longint'(fx) + ((ex != 0) ? 1024 : 0);
      my = longint'(fy) + ((ey != 0) ? 1024 : 0);
      p  = mx * my;
      e2 = ((ex == 0) ? 1 : int'(ex)) + ((ey == 0) ? 1 : int'(ey)) - 30 - 20;
      msb = 0;
      for (int i = 0; i < 40; i++) if (p[i]) msb = i;
      lg   = msb + e2;
      q    = (lg - 10 > -24) ? lg - 10 : -24;
      tiny = lg < -14;
      s    = q - e2;
      if (s <= 0) begin
         n = p <<< (-s); rem = 0; half = 1;
      end else begin
         if (s > 60) s = 60;
         n = p >> s; rem = p - (n << s); half = longint'(1) << (s - 1);
      end
      inexact = (rem != 0);
      if (!rz && (rem > half || (rem == half && n[0]))) n++;
      if (n == 2048) begin n = 1024; q++; end
      field = (n >= 1024) ? q + 25 : 0;
      if (field >= 31) begin
         res = rz ? {sg, 5'h1E, 10'h3FF} : {sg, 5'h1F, 10'h000};
         flg = 4'b0101;
         return;
      end
      res = {sg, 5'(field), n[9:0]};
      flg = {1'b0, 1'b0, tiny && inexact, inexact};
   endfunction

   function automatic logic [15:0] rand_operand();
      logic [4:0] e;
      logic [9:0] f;
      case ($urandom_range(0, 7))
         0:       e = 5'd0;
         1:       e = 5'd31;
         2:       e = 5'($urandom_range(1, 4));
         3:       e = 5'($urandom_range(26, 30));
         default: e = 5'($urandom_range(0, 31));
      endcase
      f = 10'($urandom);
      if ($urandom_range(0, 5) == 0) f = '0;
      return {1'($urandom), e, f};
   endfunction

   // Full handshake with out_ready held high; lat counts edges from acceptance to out_valid.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic trz,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; rnd_mode = trz; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); rnd_mode = ~trz;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      r = result;
      f = flags;
      @(posedge clk);
   endtask

   task automatic op_lit(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic trz, input logic [15:0] er, input logic [3:0] ef);
      logic [15:0] r;
      logic [3:0]  f;
      int          lat;
      run_op(ta, tb_v, trz, r, f, lat);
      check({tag, "_res"}, r, er);
      check({tag, "_flags"}, f, ef);
      check({tag, "_lat"}, lat, 5);
      $display("op %s: %h * %h rz=%0d -> %h flags=%b lat=%0d", tag, ta, tb_v, trz, r, f, lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra, rb, r, er;
      logic [3:0]  f, ef;
      logic        rz;
      int          lat, x0;
      bit          seen;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_mode = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      op_lit("one_x_1p5", 16'h3C00, 16'h3E00, 1'b0, 16'h3E00, 4'b0000);
      op_lit("ovf_rne", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
      op_lit("ovf_rtz", 16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, 4'b0101);
      op_lit("inf_x_0", 16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000);
      op_lit("snan", 16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000);
      op_lit("qnan", 16'h7E55, 16'h3C00, 1'b0, 16'h7E00, 4'b0000);
      op_lit("inf_neg", 16'h7C00, 16'hBC00, 1'b0, 16'hFC00, 4'b0000);
      op_lit("neg_zero", 16'h8000, 16'h4000, 1'b0, 16'h8000, 4'b0000);
      op_lit("sub_tie", 16'h0001, 16'h3800, 1'b0, 16'h0000, 4'b0011);
      op_lit("min_norm_half", 16'h0400, 16'h3800, 1'b0, 16'h0200, 4'b0000);

      for (int i = 0; i < 150; i++) begin
         ra = rand_operand(); rb = rand_operand(); rz = 1'($urandom);
         ref_mul(ra, rb, rz, er, ef);
         run_op(ra, rb, rz, r, f, lat);
         check("rand_res", r, er);
         check("rand_flags", f, ef);
         check("rand_lat", lat, 5);
         $display("op rand%0d: %h * %h rz=%0d -> %h flags=%b exp %h/%b", i, ra, rb, rz, r, f, er, ef);
      end

      // Backpressure: in_valid stays high while the result is parked.
      ref_mul(16'h4200, 16'h4200, 1'b0, er, ef);
      @(negedge clk);
      a = 16'h4200; b = 16'h4200; rnd_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      a = 16'h3C00; b = 16'h3C00;
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check("bp_result", result, er);
         check("bp_flags", flags, ef);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         @(negedge clk);
      end
      x0 = n_xfer;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_one_xfer", n_xfer - x0, 1);
      check("bp_valid_drop", out_valid, 0);
      repeat (8) @(negedge clk);
      check("bp_no_extra", n_xfer - x0, 1);
      $display("op backpressure: 4200 * 4200 held 10 cycles -> %h transfers=%0d", er, n_xfer - x0);

      // Reset while the operation sits in MULT.
      @(negedge clk);
      a = 16'h3C00; b = 16'h4400; rnd_mode = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_in_ready", in_ready, 1);
      check("mrst_out_valid", out_valid, 0);
      check("mrst_result", result, 0);
      check("mrst_flags", flags, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("mrst_no_result", seen, 0);
      $display("op midreset: in-flight op discarded, out_valid seen=%0d", seen);
      op_lit("after_rst", 16'h4000, 16'h4000, 1'b0, 16'h4400, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored fraction width; the total operand width is W = 1+EXP_W+MAN_W (16 by default, IEEE binary16).
REQ-003 SHALL have ports, one per line:
 clk  in  1  rising-edge clock
 rst_n  in  1  asynchronous active-low reset
 in_valid  in  1  operands presented
 in_ready  out  1  block can accept operands
 a  in  W  operand A
 b  in  W  operand B
 rnd_mode  in  1  0=round-nearest-even, 1=round-toward-zero; sampled with operands
 out_valid  out  1  result presented
 out_ready  in  1  consumer accepts result
 result  out  W  product
 flags  out  4  {invalid, overflow, underflow, inexact}

Function
REQ-004 SHALL accept operands on a cycle where in_valid&&in_ready, latching a, b and rnd_mode.
REQ-005 SHALL sequence the FSM IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE, one state per cycle, with DONE held until out_valid&&out_ready and then returning to IDLE.
REQ-006 SHALL drive in_ready=1 only in IDLE; the block is single-issue with no overlap between operations.
REQ-007 SHALL assert out_valid exactly 5 cycles after the acceptance edge, for every operation including special cases.
REQ-008 SHALL hold result and flags stable while out_valid=1 and out_ready=0.
REQ-009 UNPACK SHALL set the hidden bit to 1 for a nonzero exponent field, and for a zero exponent field SHALL set the hidden bit to 0 with effective exponent 1.
REQ-010 UNPACK SHALL classify each operand as zero, subnormal, normal, infinity, quiet NaN (fraction MSB=1) or signalling NaN (fraction MSB=0, fraction nonzero).
REQ-011 SHALL handle special operands with this priority:
- any NaN operand -> canonical qNaN (sign 0, exponent all-ones, fraction 100..0); invalid=1 only if an operand is an sNaN;
- inf*0 -> canonical qNaN with invalid=1;
- inf*x -> infinity with sign = sA^sB;
- zero*x -> zero with sign = sA^sB.
REQ-012 MULT SHALL form the exact (2*MAN_W+2)-bit significand product and a signed biased exponent eA+eB-bias of width EXP_W+2, where bias = 2^(EXP_W-1)-1.
REQ-013 NORM SHALL left-shift by the leading-zero count, or right-shift by 1 when the product MSB is set, and SHALL adjust the exponent to match.
REQ-014 If the NORM exponent is below 1, NORM SHALL right-shift by (1-exp), saturated at MAN_W+3, OR-ing all shifted-out bits into sticky, and SHALL set exponent 0.
REQ-015 ROUND SHALL use guard, round and sticky bits.
- RNE: increment when G&&(R||S||LSB).
- RTZ: never increment.
- A mantissa carry-out SHALL increment the exponent; a subnormal carrying into hidden SHALL become the minimum normal.
REQ-016 inexact SHALL be G|R|S for the finite path.
REQ-017 overflow SHALL be set when the rounded exponent is at least all-ones, with inexact=1 as well.
- RNE: the result is infinity.
- RTZ: the result is the maximum finite value.
REQ-018 underflow SHALL be set only when the result is tiny before rounding and inexact.
REQ-019 Flags SHALL be zero on special-case results except as stated in REQ-011.

Reset
REQ-020 Asserting rst_n=0 SHALL immediately force the FSM to IDLE and drive in_ready=1, out_valid=0, result=0 and flags=0.
REQ-021 Reset asserted mid-operation SHALL discard the in-flight operation with no result emitted.
REQ-022 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-023 A shared package fp_pkg SHALL hold:
- the state enum typedef;
- the rounding-mode enum;
- the flag bit index constants;
- a class enum for zero/sub/norm/inf/qnan/snan.
REQ-024 A sub-module fp_lzc (parametrised leading-zero counter, combinational) SHALL be instantiated by NORM.
REQ-025 All datapath widths SHALL derive from EXP_W and MAN_W, with no hard-coded 16-bit constants.

Verification (default parameters)
REQ-026 0x3C00*0x3E00, RNE -> 0x3E00, flags 0, out_valid 5 cycles after acceptance.
REQ-027 0x7BFF*0x7BFF: RNE -> 0x7C00, flags {0,1,0,1}; RTZ -> 0x7BFF, flags {0,1,0,1}.
REQ-028 0x7C00*0x0000 -> 0x7E00, invalid=1; 0x7D00*0x3C00 (sNaN) -> 0x7E00, invalid=1.
REQ-029 0x0001*0x3800, RNE -> 0x0000, flags {0,0,1,1}; 0x0400*0x3800 -> 0x0200, flags 0.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> result stable, in_ready=0 throughout; one transfer occurs when out_ready rises.
REQ-031 Pulse rst_n low in the MULT state -> out_valid never rises for that operation; the next operation 0x4000*0x4000 -> 0x4400.
